// File: rtl/seq_detect_param_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// overlap-mode encodings and the fill-counter width helper.
package seq_det_pkg;

    localparam bit SEQ_MODE_OVERLAP = 1'b1;
    localparam bit SEQ_MODE_NONOVL  = 1'b0;

    // Width of the fill counter that tracks how much of the window holds valid bits
    function automatic int fill_w(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/seq_detect_param_counter.sv
// Saturating hit counter used by seq_detect_param when MATCH_CNT_EN is defined.
// Cleared only by the asynchronous reset; holds at all-ones once full.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    // Count hits, stopping at the saturation value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != CNT_SAT)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: detects a SEQ_LEN-bit pattern (MSB received first) in a
// 1-bit stream qualified by x_valid. z is the same-cycle Mealy flag, z_reg is
// z delayed one clock. The pattern can be reloaded at run time via cfg_load.
// Optional feature macro: MATCH_CNT_EN adds the saturating match_count output.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = SEQ_MODE_OVERLAP
`ifdef MATCH_CNT_EN
    ,
    parameter int                 CNT_W   = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [SEQ_LEN-1:0] cfg_pattern,
    output logic               z,
    output logic               z_reg
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam int           CW          = fill_w(SEQ_LEN);
    localparam logic [CW-1:0] CNT_FULL   = CW'(SEQ_LEN - 1);
    localparam bit           NONOVL_MODE = (OVERLAP == SEQ_MODE_NONOVL);

    // Only the newest SEQ_LEN-1 bits are kept: together with the incoming x
    // they form the full comparison window, so the oldest bit is never read.
    logic [SEQ_LEN-1:0] pattern_r;
    logic [SEQ_LEN-2:0] hist_r;
    logic [CW-1:0]      cnt_r;

    logic               accept_s;
    logic [SEQ_LEN-1:0] window_s;
    logic               hit_s;
    logic [CW-1:0]      cnt_nxt_s;

    // Compare the full window every accepted bit; no partial-match FSM needed
    always_comb begin
        accept_s  = x_valid & ~cfg_load;
        window_s  = {hist_r, x};
        hit_s     = 1'b0;
        cnt_nxt_s = cnt_r;
        if (!reset && accept_s && (cnt_r == CNT_FULL) && (window_s == pattern_r)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (hit_s && NONOVL_MODE) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_FULL) begin
            cnt_nxt_s = CNT_FULL;
        end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign z = hit_s;

    // Pattern, history window, fill count and delayed match flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_r <= PATTERN;
            hist_r    <= {(SEQ_LEN-1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            z_reg     <= 1'b0;
        end else begin
            z_reg <= hit_s;
            if (cfg_load) begin
                // New pattern restarts the fill; the bit on this cycle is dropped
                pattern_r <= cfg_pattern;
                cnt_r     <= {CW{1'b0}};
            end else if (x_valid) begin
                hist_r <= window_s[SEQ_LEN-2:0];
                cnt_r  <= cnt_nxt_s;
            end else begin
                // Bubble: hold so a partial match survives
                hist_r <= hist_r;
                cnt_r  <= cnt_r;
            end
        end
    end

`ifdef MATCH_CNT_EN
    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_s),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param. Two instances share one input
// stream: one overlapping, one non-overlapping. A queue-based model of the
// accepted bit stream predicts z / z_reg every cycle; directed vectors carry
// hand-computed literal expectations as well.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       z_ov, zr_ov, z_no, zr_no;
`ifdef MATCH_CNT_EN
    logic [1:0] mc_ov, mc_no;
`endif

    int checks = 0;
    int failures = 0;
    int last_ov = 0;
    int last_no = 0;

    always #5 clk = ~clk;

    seq_detect_param #(
        .SEQ_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)
`ifdef MATCH_CNT_EN
        , .CNT_W(2)
`endif
    ) dut_ov (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .z(z_ov), .z_reg(zr_ov)
`ifdef MATCH_CNT_EN
        , .match_count(mc_ov)
`endif
    );

    seq_detect_param #(
        .SEQ_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)
`ifdef MATCH_CNT_EN
        , .CNT_W(2)
`endif
    ) dut_no (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .z(z_no), .z_reg(zr_no)
`ifdef MATCH_CNT_EN
        , .match_count(mc_no)
`endif
    );

    // ---------------- behavioural model ----------------
    // q_* hold the bits accepted since the last restart (reset, load, or a
    // non-overlapping hit); a hit is "at least 4 bits and the last 4 equal the pattern".
    bit       q_ov[$];
    bit       q_no[$];
    logic [3:0] mpat = 4'b1101;
    bit       mzr_ov = 1'b0;
    bit       mzr_no = 1'b0;
    int       mcnt_ov = 0;
    int       mcnt_no = 0;

    function automatic bit win_hit(input bit q[$], input logic [3:0] pat, input logic xb);
        bit t[$];
        logic [3:0] w;
        t = q;
        t.push_back(xb);
        if (t.size() < 4) return 1'b0;
        w = {t[t.size()-4], t[t.size()-3], t[t.size()-2], t[t.size()-1]};
        return (w == pat);
    endfunction

    function automatic bit exp_hit(input bit q[$]);
        return x_valid && !cfg_load && !reset && win_hit(q, mpat, x);
    endfunction

    always @(posedge clk or posedge reset) begin
        bit h_ov, h_no;
        if (reset) begin
            q_ov.delete(); q_no.delete();
            mpat = 4'b1101; mzr_ov = 1'b0; mzr_no = 1'b0;
            mcnt_ov = 0; mcnt_no = 0;
        end else begin
            h_ov = exp_hit(q_ov);
            h_no = exp_hit(q_no);
            mzr_ov = h_ov; mzr_no = h_no;
            if (h_ov && mcnt_ov < 3) mcnt_ov++;
            if (h_no && mcnt_no < 3) mcnt_no++;
            if (cfg_load) begin
                mpat = cfg_pattern;
                q_ov.delete(); q_no.delete();
            end else if (x_valid) begin
                q_ov.push_back(x); q_no.push_back(x);
                if (h_no) q_no.delete();
                while (q_ov.size() > 4) void'(q_ov.pop_front());
                while (q_no.size() > 4) void'(q_no.pop_front());
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        check("model_z_ov", {31'd0, z_ov}, {31'd0, exp_hit(q_ov)});
        check("model_z_no", {31'd0, z_no}, {31'd0, exp_hit(q_no)});
        check("model_zr_ov", {31'd0, zr_ov}, {31'd0, mzr_ov});
        check("model_zr_no", {31'd0, zr_no}, {31'd0, mzr_no});
`ifdef MATCH_CNT_EN
        check("model_cnt_ov", {30'd0, mc_ov}, mcnt_ov);
        check("model_cnt_no", {30'd0, mc_no}, mcnt_no);
`endif
    end

    // ---------------- directed stimulus ----------------
    // Drive one cycle; e_* are literal z expectations (-1 = don't care).
    // z_reg is checked against the previous cycle's literal z expectation.
    task automatic send(input logic v, input logic b, input logic ld,
                        input logic [3:0] p, input int e_ov, input int e_no);
        @(posedge clk);
        #1;
        x_valid = v; x = b; cfg_load = ld; cfg_pattern = p;
        #2;
        if (e_ov >= 0) check("lit_z_ov", {31'd0, z_ov}, e_ov);
        if (e_no >= 0) check("lit_z_no", {31'd0, z_no}, e_no);
        if (last_ov >= 0) check("lit_zr_ov", {31'd0, zr_ov}, last_ov);
        if (last_no >= 0) check("lit_zr_no", {31'd0, zr_no}, last_no);
        last_ov = e_ov;
        last_no = e_no;
    endtask

    task automatic bit1(input logic b, input int e_ov, input int e_no);
        send(1'b1, b, 1'b0, 4'b0000, e_ov, e_no);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_z_ov", {31'd0, z_ov}, 0);
        check("rst_z_no", {31'd0, z_no}, 0);
        check("rst_zr_ov", {31'd0, zr_ov}, 0);
        check("rst_zr_no", {31'd0, zr_no}, 0);
        x_valid = 1'b0; cfg_load = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_ov = 0; last_no = 0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("init_z", {31'd0, z_ov}, 0);
        check("init_zr", {31'd0, zr_ov}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1/2: 1,1,0,1,1,0,1 -> overlap hits bits 4 and 7, non-overlap bit 4 only
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0); bit1(1'b1, 1, 1);
        bit1(1'b1, 0, 0); bit1(1'b0, 0, 0); bit1(1'b1, 1, 0);
        send(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);

        // 3: bubbles with toggling x never break a partial match
        do_reset();
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0);
        send(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);
        send(1'b0, 1'b1, 1'b0, 4'b0000, 0, 0);
        send(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);
        bit1(1'b0, 0, 0); bit1(1'b1, 1, 1);

        // 4: load 0110 on the cycle x would complete 1101 -> no z, then 0,1,1,0 hits
        do_reset();
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0);
        send(1'b1, 1'b1, 1'b1, 4'b0110, 0, 0);
        bit1(1'b0, 0, 0); bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 1, 1);

        // 5: reset right after a hit clears z_reg at once; reset mid-pattern restarts fill
        do_reset();
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0); bit1(1'b1, 1, 1);
        do_reset();
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0);
        do_reset();
        bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0); bit1(1'b1, 1, 1);

`ifdef MATCH_CNT_EN
        // 6: five hits, counter saturates at 3
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            bit1(1'b1, 0, 0); bit1(1'b1, 0, 0); bit1(1'b0, 0, 0); bit1(1'b1, 1, 1);
            send(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);
            check("lit_cnt_ov", {30'd0, mc_ov}, (k > 3) ? 3 : k);
            check("lit_cnt_no", {30'd0, mc_no}, (k > 3) ? 3 : k);
        end
        // cfg_load must not clear the counter
        send(1'b1, 1'b0, 1'b1, 4'b1101, 0, 0);
        send(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0);
        check("lit_cnt_load", {30'd0, mc_ov}, 3);
`endif

        // Mixed stream: bubbles, occasional reloads; model-checked every cycle
        do_reset();
        for (int i = 0; i < 200; i++) begin
            send(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), -1, -1);
        end
        send(1'b0, 1'b0, 1'b0, 4'b0000, -1, -1);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
